// File: rtl/trig_event_complete.sv
// In-order tracker of up to four outstanding triggered events; pulses last_flag_o
// once per event when all required SURFs have delivered it or the head times out.
module trig_event_complete #(
  parameter int NSURF   = 28,
  parameter int TIMEOUT = 1250000
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_i,
  input  logic             trig_i,
  input  logic [NSURF-1:0] surf_mask_i,
  input  logic [NSURF-1:0] surf_done_i,
  output logic             last_flag_o,
  output logic [2:0]       pending_o,
  output logic             overflow_err_o,
  output logic             stray_err_o,
  output logic             timeout_err_o,
  output logic [NSURF-1:0] missing_o
);

  localparam bit          TMO_EN   = (TIMEOUT > 0);
  localparam logic [31:0] TMO_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  logic [3:0]       valid_reg;
  logic [NSURF-1:0] req_reg  [4];
  logic [NSURF-1:0] done_reg [4];
  logic [1:0]       head_reg;
  logic [1:0]       tail_reg;
  logic [2:0]       count_reg;
  logic [31:0]      tmo_cnt_reg;
  logic             last_flag_reg;
  logic             overflow_reg;
  logic             stray_reg;
  logic             timeout_reg;
  logic [NSURF-1:0] missing_reg;

  logic [NSURF-1:0]   head_missing;
  logic               head_complete;
  logic               tmo_fire;
  logic               rel_evt;
  logic               alloc;
  logic [4*NSURF-1:0] set_flat;
  logic [NSURF-1:0]   stray_vec;

  assign head_missing  = req_reg[head_reg] & ~done_reg[head_reg];
  assign head_complete = valid_reg[head_reg] && (head_missing == '0);
  assign tmo_fire      = TMO_EN && valid_reg[head_reg] && !head_complete &&
                         (tmo_cnt_reg == TMO_LAST);
  assign rel_evt       = head_complete || tmo_fire;
  assign alloc         = trig_i && (count_reg != 3'd4);

  // Per SURF: rotate eligibility so the head is bit 0, pick the lowest set bit,
  // rotate back. A head that releases this cycle is never a target.
  genvar gi, gk;
  generate
    for (gi = 0; gi < NSURF; gi++) begin : g_surf
      logic [3:0] elig;
      logic [3:0] elig_rot;
      logic [3:0] pick_rot;
      logic [3:0] pick;
      for (gk = 0; gk < 4; gk++) begin : g_slot
        assign elig[gk] = valid_reg[gk] && req_reg[gk][gi] && !done_reg[gk][gi] &&
                          !(rel_evt && (head_reg == 2'(gk)));
        assign elig_rot[gk] = elig[head_reg + 2'(gk)];
        assign pick[gk]     = pick_rot[2'(gk) - head_reg];
        assign set_flat[gk*NSURF + gi] = surf_done_i[gi] && pick[gk];
      end
      assign pick_rot      = elig_rot & (~elig_rot + 4'd1);
      assign stray_vec[gi] = surf_done_i[gi] && (elig == 4'd0);
    end
  endgenerate

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      valid_reg     <= '0;
      for (int k = 0; k < 4; k++) begin
        req_reg[k]  <= '0;
        done_reg[k] <= '0;
      end
      head_reg      <= '0;
      tail_reg      <= '0;
      count_reg     <= '0;
      tmo_cnt_reg   <= '0;
      last_flag_reg <= 1'b0;
      overflow_reg  <= 1'b0;
      stray_reg     <= 1'b0;
      timeout_reg   <= 1'b0;
      missing_reg   <= '0;
    end else begin
      // Allocation and release never hit the same slot: alloc needs count<4,
      // so the tail slot is always invalid when written.
      for (int k = 0; k < 4; k++) begin
        if (alloc && (tail_reg == 2'(k))) begin
          valid_reg[k] <= 1'b1;
          req_reg[k]   <= surf_mask_i;
          done_reg[k]  <= '0;
        end else if (rel_evt && (head_reg == 2'(k))) begin
          valid_reg[k] <= 1'b0;
          req_reg[k]   <= '0;
          done_reg[k]  <= '0;
        end else begin
          done_reg[k]  <= done_reg[k] | set_flat[k*NSURF +: NSURF];
        end
      end
      if (rel_evt) head_reg <= head_reg + 2'd1;
      if (alloc)   tail_reg <= tail_reg + 2'd1;
      count_reg <= count_reg + {2'b00, alloc} - {2'b00, rel_evt};

      if (rel_evt || !valid_reg[head_reg])
        tmo_cnt_reg <= '0;
      else if (TMO_EN)
        tmo_cnt_reg <= tmo_cnt_reg + 32'd1;

      last_flag_reg <= rel_evt;
      if (trig_i && (count_reg == 3'd4)) overflow_reg <= 1'b1;
      if (|stray_vec) stray_reg <= 1'b1;
      if (tmo_fire) begin
        timeout_reg <= 1'b1;
        missing_reg <= head_missing;
      end
    end
  end

  assign last_flag_o    = last_flag_reg;
  assign pending_o      = count_reg;
  assign overflow_err_o = overflow_reg;
  assign stray_err_o    = stray_reg;
  assign timeout_err_o  = timeout_reg;
  assign missing_o      = missing_reg;

endmodule

// File: tb/tb_trig_event_complete.sv
// Directed scenarios plus random traffic, checked every cycle against a queue model.
module tb_trig_event_complete;

  localparam int NSURF   = 28;
  localparam int TIMEOUT = 100;

  logic             sys_clk_i = 1'b0;
  logic             sys_rst_i = 1'b0;
  logic             trig_i = 1'b0;
  logic [NSURF-1:0] surf_mask_i = '0;
  logic [NSURF-1:0] surf_done_i = '0;
  logic             last_flag_o;
  logic [2:0]       pending_o;
  logic             overflow_err_o;
  logic             stray_err_o;
  logic             timeout_err_o;
  logic [NSURF-1:0] missing_o;

  trig_event_complete #(.NSURF(NSURF), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk_i      (sys_clk_i),
    .sys_rst_i      (sys_rst_i),
    .trig_i         (trig_i),
    .surf_mask_i    (surf_mask_i),
    .surf_done_i    (surf_done_i),
    .last_flag_o    (last_flag_o),
    .pending_o      (pending_o),
    .overflow_err_o (overflow_err_o),
    .stray_err_o    (stray_err_o),
    .timeout_err_o  (timeout_err_o),
    .missing_o      (missing_o)
  );

  always #5 sys_clk_i = ~sys_clk_i;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Reference model: events as a FIFO of required/delivered masks.
  logic [NSURF-1:0] req_q[$];
  logic [NSURF-1:0] done_q[$];
  int               wait_cnt = 0;
  logic             exp_flag = 1'b0;
  logic             exp_ovf = 1'b0;
  logic             exp_stray = 1'b0;
  logic             exp_tmo = 1'b0;
  logic [NSURF-1:0] exp_missing = '0;

  task automatic model(input logic rst, input logic trig,
                       input logic [NSURF-1:0] mask, input logic [NSURF-1:0] dn);
    logic rel;
    logic forced;
    logic hit;
    int   first;
    int   old_size;
    logic [NSURF-1:0] tmp;
    if (rst) begin
      req_q.delete();
      done_q.delete();
      wait_cnt    = 0;
      exp_flag    = 1'b0;
      exp_ovf     = 1'b0;
      exp_stray   = 1'b0;
      exp_tmo     = 1'b0;
      exp_missing = '0;
      return;
    end
    rel      = 1'b0;
    forced   = 1'b0;
    old_size = req_q.size();
    if (old_size > 0) begin
      if ((req_q[0] & ~done_q[0]) == '0) rel = 1'b1;
      else if (wait_cnt == TIMEOUT - 1) begin
        rel    = 1'b1;
        forced = 1'b1;
      end
    end
    first = rel ? 1 : 0;
    for (int s = 0; s < NSURF; s++) begin
      if (dn[s]) begin
        hit = 1'b0;
        for (int i = first; i < req_q.size(); i++) begin
          if (!hit && req_q[i][s] && !done_q[i][s]) begin
            tmp       = done_q[i];
            tmp[s]    = 1'b1;
            done_q[i] = tmp;
            hit       = 1'b1;
          end
        end
        if (!hit) exp_stray = 1'b1;
      end
    end
    if (forced) begin
      exp_tmo     = 1'b1;
      exp_missing = req_q[0] & ~done_q[0];
    end
    if (trig && old_size == 4) exp_ovf = 1'b1;
    if (rel) begin
      void'(req_q.pop_front());
      void'(done_q.pop_front());
    end
    if (trig && old_size < 4) begin
      req_q.push_back(mask);
      done_q.push_back('0);
    end
    wait_cnt = (rel || old_size == 0) ? 0 : wait_cnt + 1;
    exp_flag = rel;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, obs, expv);
    end
  endtask

  task automatic check_all();
    chk("last_flag", 32'(last_flag_o), 32'(exp_flag));
    chk("pending", 32'(pending_o), 32'(req_q.size()));
    chk("overflow_err", 32'(overflow_err_o), 32'(exp_ovf));
    chk("stray_err", 32'(stray_err_o), 32'(exp_stray));
    chk("timeout_err", 32'(timeout_err_o), 32'(exp_tmo));
    chk("missing", 32'(missing_o), 32'(exp_missing));
  endtask

  // Drive one cycle of inputs, apply the edge to the model, check just after it.
  task automatic step(input logic rst, input logic trig,
                      input logic [NSURF-1:0] mask, input logic [NSURF-1:0] dn);
    sys_rst_i   = rst;
    trig_i      = trig;
    surf_mask_i = mask;
    surf_done_i = dn;
    @(posedge sys_clk_i);
    model(rst, trig, mask, dn);
    cyc++;
    #1;
    check_all();
    sys_rst_i   = 1'b0;
    trig_i      = 1'b0;
    surf_done_i = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0);
  endtask

  int flags_seen;
  logic [NSURF-1:0] rmask;
  logic [NSURF-1:0] rdone;

  initial begin
    // Reset state
    step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b0, '0, '0);
    chk("reset_pending", 32'(pending_o), 32'd0);

    // Two-SURF event: flag exactly two cycles after the final done pulse
    step(1'b0, 1'b1, 28'h0000003, '0);
    idle(8);
    step(1'b0, 1'b0, '0, 28'h1);
    idle(9);
    step(1'b0, 1'b0, '0, 28'h2);
    chk("latency_n1_flag", 32'(last_flag_o), 32'd0);
    step(1'b0, 1'b0, '0, '0);
    chk("latency_n2_flag", 32'(last_flag_o), 32'd1);
    chk("latency_n2_pending", 32'(pending_o), 32'd0);
    step(1'b0, 1'b0, '0, '0);
    chk("flag_single_cycle", 32'(last_flag_o), 32'd0);

    // Overflow, then four releases on consecutive cycles
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 28'h1, '0);
    chk("overflow_set", 32'(overflow_err_o), 32'd1);
    chk("overflow_pending", 32'(pending_o), 32'd4);
    flags_seen = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0, 28'h1);
      flags_seen += int'(last_flag_o);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, '0, '0);
      flags_seen += int'(last_flag_o);
    end
    chk("overflow_flag_count", 32'(flags_seen), 32'd4);

    // Per-SURF in-order accounting across slots
    step(1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 28'h3, '0);
    step(1'b0, 1'b1, 28'h2, '0);
    step(1'b0, 1'b0, '0, 28'h2);
    step(1'b0, 1'b0, '0, 28'h2);
    step(1'b0, 1'b0, '0, 28'h1);
    idle(1);
    chk("inorder_first_flag", 32'(last_flag_o), 32'd1);
    idle(1);
    chk("inorder_second_flag", 32'(last_flag_o), 32'd1);
    idle(2);

    // Stray pulse with nothing pending
    step(1'b0, 1'b0, '0, 28'h20);
    chk("stray_set", 32'(stray_err_o), 32'd1);
    idle(2);

    // Timeout with SURF2 missing, then a late SURF2 pulse is stray
    step(1'b1, 1'b0, '0, '0);
    step(1'b0, 1'b1, 28'h5, '0);
    step(1'b0, 1'b0, '0, 28'h1);
    idle(TIMEOUT + 4);
    chk("timeout_err", 32'(timeout_err_o), 32'd1);
    chk("timeout_missing", 32'(missing_o), 32'h4);
    chk("timeout_stray_before", 32'(stray_err_o), 32'd0);
    step(1'b0, 1'b0, '0, 28'h4);
    chk("timeout_stray_after", 32'(stray_err_o), 32'd1);

    // Reset mid-operation discards events; zero-mask event releases immediately
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 28'h8, '0);
    step(1'b1, 1'b0, '0, '0);
    chk("midreset_pending", 32'(pending_o), 32'd0);
    chk("midreset_flag", 32'(last_flag_o), 32'd0);
    step(1'b0, 1'b1, '0, '0);
    step(1'b0, 1'b0, '0, '0);
    chk("zero_mask_flag", 32'(last_flag_o), 32'd1);
    idle(3);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      rmask = 28'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) rmask[NSURF-1] = 1'b1;
      rdone = ($urandom_range(0, 2) == 0) ? 28'($urandom_range(0, 15)) : '0;
      if ($urandom_range(0, 9) == 0) rdone[NSURF-1] = 1'b1;
      step(($urandom_range(0, 799) == 0), ($urandom_range(0, 3) == 0), rmask, rdone);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/trig_event_complete.md
Name: trig_event_complete

Overview:
- Producer of the per-event "event complete and in RAM" pulse consumed by the trigger buffer tracker.
- Keeps an in-order queue of up to 4 outstanding triggered events. For each event it records which SURFs must deliver data and which have delivered.
- Pulses last_flag_o once per event, in trigger order, when every required SURF has completed that event or its timeout expires.
- Sits in sys_clk_i domain between the master trigger process and the SURF readout/event-builder path.

Parameters:
- NSURF, 28, number of SURF readout channels; width of mask/done/missing vectors.
- TIMEOUT, 1250000, sys_clk_i cycles the head event may wait before forced release; 0 disables timeout.

Ports:
- sys_clk_i  in  1  system clock; sole clock.
- sys_rst_i  in  1  synchronous active-high reset.
- trig_i  in  1  single-cycle trigger issued; allocates tail slot.
- surf_mask_i  in  NSURF  SURFs required for an event; sampled only on trig_i.
- surf_done_i  in  NSURF  per-SURF single-cycle pulse: that SURF finished writing its oldest outstanding event to RAM.
- last_flag_o  out  1  single-cycle pulse: head event complete, buffer released.
- pending_o  out  3  outstanding events, 0..4.
- overflow_err_o  out  1  sticky: trig_i arrived with 4 pending.
- stray_err_o  out  1  sticky: surf_done_i bit with no eligible slot.
- timeout_err_o  out  1  sticky: an event was force-released.
- missing_o  out  NSURF  required-but-not-done bits of the most recent forced release.

Behaviour:
- Storage: 4 slots in a circular queue with 2-bit head/tail pointers and a 3-bit count. Each slot holds valid, req[NSURF], done[NSURF]. A single 32-bit timeout counter tracks the head slot.
- Reset (sys_rst_i high at a clock edge), effective next cycle:
  - Outputs: last_flag_o=0, pending_o=0, all errors=0, missing_o=0.
  - Internal: slots invalid, pointers 0, timeout counter 0.
  - Reset mid-operation discards all outstanding events without emitting last_flag_o.
  - Reset has priority over every other input that cycle.
- Allocation: trig_i with count<4 writes the tail slot: valid=1, req=surf_mask_i, done=0; tail++.
  - trig_i with count==4: trigger dropped, overflow_err_o=1.
  - A slot allocated in cycle N accepts done pulses from cycle N+1 onward.
- Done accounting, per SURF bit s, each cycle: if surf_done_i[s], set done[s] in the oldest valid slot (search from head, in queue order, over registered state) with req[s]=1 and done[s]=0.
  - If no such slot exists, set stray_err_o=1 and drop the pulse.
  - SURFs are independent: several bits in one cycle may target different slots.
- Completion: head slot is complete when valid and (req & ~done)==0, evaluated on registered state.
  - On completion: clear the slot, head++, and assert last_flag_o the following cycle.
  - At most one release per cycle, so back-to-back complete slots release on consecutive cycles.
  - All-zero mask completes on the first cycle it is head.
  - Latency: final done pulse in cycle N → done bit set at N+1 → release evaluated at N+1 → last_flag_o high in cycle N+2, for exactly one cycle.
- Timeout (TIMEOUT>0):
  - Counter clears whenever head changes or no slot is valid; otherwise increments while the head is incomplete.
  - When it reaches TIMEOUT-1 with the head incomplete, force release exactly as a normal completion: last_flag_o pulses, timeout_err_o=1, missing_o=req&~done of that slot.
  - Done pulses for a force-released event then count as stray (or land on the next event requiring that SURF).
- Simultaneity:
  - trig_i and a release in the same cycle: both take effect; count unchanged.
  - A done pulse arriving in the cycle the head releases applies against pre-release state. If it targets the head bit it is redundant only if that bit is already done; otherwise it goes to a later slot.
  - Release with 4 pending frees a slot; a trig_i in that same cycle is still dropped, because the count check uses registered state.
- pending_o equals the registered count, updated in the same cycle as the pointers.
- Pointers and count wrap modulo 4; count never exceeds 4 or goes below 0.

Test Plan:
- Reset, trig_i with mask 0x0000003, surf_done_i bit0 at cycle 10, bit1 at cycle 20 → last_flag_o single pulse at cycle 22; pending_o 1→0 at cycle 22.
- 4 triggers mask 0x1, then 5th trig_i → overflow_err_o=1, pending_o stays 4. Then 4 bit0 done pulses, one per cycle → exactly 4 last_flag_o pulses on consecutive cycles; dropped event never flags.
- Two triggers (masks 0x3, 0x2), SURF1 done twice then SURF0 done once → SURF1 pulses fill slots 0 and 1 in order. SURF0 done → two last_flag_o pulses on consecutive cycles.
- surf_done_i bit5 with pending_o=0 → stray_err_o=1, no last_flag_o.
- TIMEOUT=100, trig_i mask 0x5, only bit0 done → last_flag_o at TIMEOUT boundary, timeout_err_o=1, missing_o=0x4. A later bit2 pulse → stray_err_o=1.
- 3 events pending, sys_rst_i asserted one cycle → pending_o=0, errors cleared, no last_flag_o. A subsequent trig_i with mask 0 → last_flag_o two cycles later.
